// File: rtl/tlt_led_blinker.sv
// Board-level blinker demo: a prescaler produces a slow tick that steps a decimal
// digit shown on HEX0 and as a one-hot (optionally blinking) LED position on LEDR.
module tlt_led_blinker #(
  parameter int unsigned TICK_BITS = 6,
  parameter logic [1:0]  STEP      = 2'd1,
  parameter bit          BLINK     = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0
);

  localparam logic [TICK_BITS-1:0] PRESC_ONE = TICK_BITS'(1);
  localparam logic [4:0]           DIGIT_MOD = 5'd10;

  logic                 rst_n;
  logic                 run;
  logic                 unused_keys;

  logic [TICK_BITS-1:0] prescaler;
  logic [TICK_BITS-1:0] prescaler_next;
  logic [3:0]           digit;
  logic [3:0]           digit_next;
  logic                 phase;
  logic                 phase_next;
  logic                 tick;
  logic [4:0]           digit_sum;
  logic [4:0]           digit_wrapped;

  assign rst_n       = KEY[1];
  assign run         = KEY[0];
  assign unused_keys = ^KEY[3:2];

  assign tick = (prescaler == '1) && run;

  // Five-bit sum so digit+STEP never overflows before the modulo-10 correction.
  always_comb begin
    digit_sum     = {1'b0, digit} + {3'b000, STEP};
    digit_wrapped = digit_sum;
    if (digit_sum >= DIGIT_MOD) begin
      digit_wrapped = digit_sum - DIGIT_MOD;
    end
  end

  always_comb begin
    prescaler_next = prescaler;
    digit_next     = digit;
    phase_next     = phase;
    if (run) begin
      prescaler_next = prescaler + PRESC_ONE;
    end
    if (tick) begin
      digit_next = digit_wrapped[3:0];
      phase_next = BLINK ? ~phase : 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      digit     <= 4'd0;
      phase     <= 1'b1;
    end else begin
      prescaler <= prescaler_next;
      digit     <= digit_next;
      phase     <= phase_next;
    end
  end

  assign LEDR = phase ? (10'b00_0000_0001 << digit) : 10'b00_0000_0000;

  // Active-low segments, bit order g..a; unreachable codes blank the display.
  always_comb begin
    HEX0 = 7'h7F;
    case (digit)
      4'd0:    HEX0 = 7'h40;
      4'd1:    HEX0 = 7'h79;
      4'd2:    HEX0 = 7'h24;
      4'd3:    HEX0 = 7'h30;
      4'd4:    HEX0 = 7'h19;
      4'd5:    HEX0 = 7'h12;
      4'd6:    HEX0 = 7'h02;
      4'd7:    HEX0 = 7'h78;
      4'd8:    HEX0 = 7'h00;
      4'd9:    HEX0 = 7'h10;
      default: HEX0 = 7'h7F;
    endcase
  end

endmodule

// File: tb/tb_tlt_led_blinker.sv
// Directed bench for tlt_led_blinker: a default instance (blinking, step 1) and a
// fast instance with STEP=3, BLINK=0, both checked against hand-computed values.
module tb_tlt_led_blinker;

  logic       clock = 1'b0;
  logic [3:0] key_a;
  logic [3:0] key_b;
  logic [9:0] ledr_a;
  logic [9:0] ledr_b;
  logic [6:0] hex_a;
  logic [6:0] hex_b;

  int compare_count  = 0;
  int mismatch_count = 0;

  logic [6:0] hex_table [10];
  int         b_digits  [6];
  logic [9:0] b_leds    [6];

  always #4 clock = ~clock;

  tlt_led_blinker #(.TICK_BITS(6), .STEP(2'd1), .BLINK(1'b1)) dut_a (
    .CLOCK_50 (clock),
    .KEY      (key_a),
    .LEDR     (ledr_a),
    .HEX0     (hex_a)
  );

  tlt_led_blinker #(.TICK_BITS(3), .STEP(2'd3), .BLINK(1'b0)) dut_b (
    .CLOCK_50 (clock),
    .KEY      (key_b),
    .LEDR     (ledr_b),
    .HEX0     (hex_b)
  );

  task automatic checkOutput(input string tag, input logic [9:0] observed, input logic [9:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: observed %03h expected %03h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] value_a, input logic [3:0] value_b);
    key_a = value_a;
    key_b = value_b;
  endtask

  // Land one time unit after the rising edge so outputs are stable when sampled.
  task automatic waitEdges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic checkA(input string tag, input int digit, input bit phase);
    checkOutput({tag, "_ledr"}, ledr_a, phase ? (10'd1 << digit) : 10'd0);
    checkOutput({tag, "_hex"}, {3'b000, hex_a}, {3'b000, hex_table[digit]});
  endtask

  initial begin
    hex_table = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    b_digits  = '{0, 3, 6, 9, 2, 5};
    b_leds    = '{10'h001, 10'h008, 10'h040, 10'h200, 10'h004, 10'h020};

    applyStimulus(4'b0001, 4'b0001);
    #10;
    checkA("reset", 0, 1'b1);

    applyStimulus(4'b0011, 4'b0001);
    waitEdges(63);
    checkA("pre_tick1", 0, 1'b1);
    waitEdges(1);
    checkA("tick1", 1, 1'b0);
    waitEdges(64);
    checkA("tick2", 2, 1'b1);

    for (int n = 3; n <= 10; n++) begin
      waitEdges(63);
      checkA($sformatf("hold%0d", n), (n - 1) % 10, ((n - 1) % 2) == 0);
      waitEdges(1);
      checkA($sformatf("tick%0d", n), n % 10, (n % 2) == 0);
    end

    // Prescaler restarted at 0 on tick 10; stop it at 31, leaving 33 edges to the next tick.
    waitEdges(31);
    checkA("pre_pause", 0, 1'b1);
    applyStimulus(4'b0010, 4'b0001);
    #100;
    checkA("paused", 0, 1'b1);
    @(posedge clock);
    #1;
    checkA("paused_late", 0, 1'b1);
    applyStimulus(4'b0011, 4'b0001);
    waitEdges(32);
    checkA("resume_hold", 0, 1'b1);
    waitEdges(1);
    checkA("resume_tick", 1, 1'b0);

    for (int n = 12; n <= 15; n++) begin
      waitEdges(64);
      checkA($sformatf("tick%0d", n), n % 10, (n % 2) == 0);
    end

    waitEdges(20);
    applyStimulus(4'b0001, 4'b0001);
    #2;
    checkA("async_reset", 0, 1'b1);
    #98;
    checkA("reset_held", 0, 1'b1);
    @(posedge clock);
    #1;
    applyStimulus(4'b0011, 4'b0001);
    waitEdges(63);
    checkA("post_reset_hold", 0, 1'b1);
    waitEdges(1);
    checkA("post_reset_tick", 1, 1'b0);

    checkOutput("b_reset_ledr", ledr_b, 10'h001);
    checkOutput("b_reset_hex", {3'b000, hex_b}, {3'b000, 7'h40});
    applyStimulus(4'b0011, 4'b1111);
    waitEdges(7);
    checkOutput("b_hold_ledr", ledr_b, 10'h001);
    waitEdges(1);
    for (int k = 1; k < 6; k++) begin
      if (k > 1) waitEdges(8);
      checkOutput($sformatf("b_step%0d_ledr", k), ledr_b, b_leds[k]);
      checkOutput($sformatf("b_step%0d_hex", k), {3'b000, hex_b}, {3'b000, hex_table[b_digits[k]]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
